alu_result_bcd: RTL and testbench



---
 rtl/alu_result_bcd.sv | 190 +++++++++++++++++++
 tb/tb_alu_result_bcd.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_bcd.sv
// alu_result_bcd
// Sequential binary-to-BCD converter for the ALU result display path.
// Uses shift-add-3 (double dabble) and processes one bit per clock, with a
// start/done handshake. A subtract result with its MSB set is shown as a
// magnitude plus a negative flag. The undefined opcode 2'b11 produces an
// all-ones digit pattern and raises err.
module alu_result_bcd #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic [1:0]            operation,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg,
    output logic                  err
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    // DONE is never entered: the final shift edge loads the outputs and
    // returns to IDLE directly. This lets a start presented during the
    // done cycle be accepted at the very next edge. DONE is kept as a
    // decoded state so that an upset into it recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [BIN_W-1:0]   opnd_q,     opnd_d;
    logic [BCD_W-1:0]   acc_q,      acc_d;
    logic               pend_neg_q, pend_neg_d;
    logic               pend_err_q, pend_err_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic               neg_q,      neg_d;
    logic               err_q,      err_d;

    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   acc_next_s;
    logic [BIN_W-1:0]   opnd_next_s;
    logic               last_shift_s;

    // Adds 3 to every BCD digit that is 5 or more, before the next shift.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    // One double-dabble step: adjust the digits, then shift {acc, operand} left by one.
    always_comb begin
        adj_s        = add3_digits(acc_q);
        acc_next_s   = {adj_s[BCD_W-2:0], opnd_q[BIN_W-1]};
        opnd_next_s  = {opnd_q[BIN_W-2:0], 1'b0};
        last_shift_s = (cnt_q == CNT_W'(BIN_W - 1));
    end

    // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        pend_neg_d = pend_neg_q;
        pend_err_d = pend_err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    acc_d   = '0;
                    case (operation)
                        2'b01: begin
                            // Subtract: a set MSB means negative, so convert to magnitude.
                            if (bin_in[BIN_W-1]) begin
                                opnd_d     = (~bin_in) + {{(BIN_W-1){1'b0}}, 1'b1};
                                pend_neg_d = 1'b1;
                            end else begin
                                opnd_d     = bin_in;
                                pend_neg_d = 1'b0;
                            end
                            pend_err_d = 1'b0;
                        end
                        2'b11: begin
                            opnd_d     = '0;
                            pend_neg_d = 1'b0;
                            pend_err_d = 1'b1;
                        end
                        default: begin
                            opnd_d     = bin_in;
                            pend_neg_d = 1'b0;
                            pend_err_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                acc_d  = acc_next_s;
                opnd_d = opnd_next_s;
                if (last_shift_s) begin
                    // Final shift: publish the result and return to IDLE on this same edge.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = pend_err_q ? {BCD_W{1'b1}} : acc_next_s;
                    neg_d   = pend_neg_q & ~pend_err_q;
                    err_d   = pend_err_q;
                end else begin
                    state_d = ST_SHIFT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; an asynchronous reset abandons any conversion in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            pend_neg_q <= 1'b0;
            pend_err_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            pend_neg_q <= pend_neg_d;
            pend_err_q <= pend_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign neg     = neg_q;
    assign err     = err_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Self-checking bench for alu_result_bcd: a directed vector table, randomized
// conversions scored against a decimal-arithmetic model, and hand-written
// handshake, busy-ignore and mid-conversion reset sequences.
module tb_alu_result_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  bin_in;
    logic [1:0]  operation;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        neg;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_bcd #(.BIN_W(10), .DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin_in    (bin_in),
        .operation (operation),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .neg       (neg),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  bin;
        logic [15:0] bcd;
        logic        neg;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: decimal digits from plain integer arithmetic.
    task automatic model(input logic [1:0] op, input logic [9:0] b,
                         output logic [15:0] bcd, output logic n, output logic e);
        int mag;
        if (op == 2'd3) begin
            bcd = 16'hFFFF;
            n   = 1'b0;
            e   = 1'b1;
        end else begin
            e = 1'b0;
            if (op == 2'd1 && b >= 10'd512) begin
                mag = 1024 - int'(b);
                n   = 1'b1;
            end else begin
                mag = int'(b);
                n   = 1'b0;
            end
            bcd = {4'((mag / 1000) % 10), 4'((mag / 100) % 10),
                   4'((mag / 10) % 10), 4'(mag % 10)};
        end
    endtask

    // One conversion: start pulse, measured latency, then the result.
    task automatic do_conv(input logic [1:0] op, input logic [9:0] b,
                           input logic [15:0] e_bcd, input logic e_neg,
                           input logic e_err, input string tag);
        int cyc;
        @(negedge clk);
        start     = 1'b1;
        bin_in    = b;
        operation = op;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        chk({tag, " latency"}, 32'(cyc), 32'd10);
        chk({tag, " bcd"}, 32'(bcd_out), 32'(e_bcd));
        chk({tag, " neg"}, 32'(neg), 32'(e_neg));
        chk({tag, " err"}, 32'(err), 32'(e_err));
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] m_bcd;
        logic        m_neg;
        logic        m_err;
        logic [1:0]  r_op;
        logic [9:0]  r_bin;
        int          cyc;
        int          n_done;
        int          idx0;
        int          idx1;

        vecs[0] = '{2'd0, 10'd12,   16'h0012, 1'b0, 1'b0};
        vecs[1] = '{2'd2, 10'd961,  16'h0961, 1'b0, 1'b0};
        vecs[2] = '{2'd0, 10'd1023, 16'h1023, 1'b0, 1'b0};
        vecs[3] = '{2'd1, 10'h3FE,  16'h0002, 1'b1, 1'b0};
        vecs[4] = '{2'd1, 10'h200,  16'h0512, 1'b1, 1'b0};
        vecs[5] = '{2'd1, 10'h00A,  16'h0010, 1'b0, 1'b0};
        vecs[6] = '{2'd3, 10'd155,  16'hFFFF, 1'b0, 1'b1};
        vecs[7] = '{2'd0, 10'd5,    16'h0005, 1'b0, 1'b0};
        vecs[8] = '{2'd2, 10'd0,    16'h0000, 1'b0, 1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        bin_in    = 10'd0;
        operation = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bcd", 32'(bcd_out), 32'd0);
        chk("reset neg_err", 32'({neg, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            do_conv(vecs[i].op, vecs[i].bin, vecs[i].bcd, vecs[i].neg, vecs[i].err,
                    $sformatf("vec%0d", i));
        end

        // Randomized conversions against the model.
        for (int i = 0; i < 40; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_bin = 10'($urandom_range(0, 1023));
            model(r_op, r_bin, m_bcd, m_neg, m_err);
            do_conv(r_op, r_bin, m_bcd, m_neg, m_err, $sformatf("rnd%0d", i));
        end

        // start held high for 25 edges: exactly two done pulses, 11 apart.
        @(negedge clk);
        start     = 1'b1;
        bin_in    = 10'd7;
        operation = 2'd0;
        n_done = 0;
        idx0   = -1;
        idx1   = -1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (idx0 < 0) idx0 = k;
                else if (idx1 < 0) idx1 = k;
                chk("hold bcd", 32'(bcd_out), 32'h0007);
            end
        end
        start = 1'b0;
        chk("hold done count", 32'(n_done), 32'd2);
        chk("hold spacing", 32'(idx1 - idx0), 32'd11);
        cyc = 0;
        while (cyc < 20 && !done) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("hold drain", 32'(done), 32'd1);

        // A start pulse while busy must not disturb the conversion in progress.
        @(negedge clk);
        start     = 1'b1;
        bin_in    = 10'd300;
        operation = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (cyc == 3) begin
                start     = 1'b1;
                bin_in    = 10'd999;
                operation = 2'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("ignore latency", 32'(cyc), 32'd10);
        chk("ignore bcd", 32'(bcd_out), 32'h0300);
        chk("ignore err", 32'(err), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("ignore no restart", 32'(busy), 32'd0);

        // Asynchronous reset four cycles into a conversion.
        @(negedge clk);
        start     = 1'b1;
        bin_in    = 10'd456;
        operation = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst bcd", 32'(bcd_out), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("midrst no done", 32'(n_done), 32'd0);
        do_conv(2'd0, 10'd789, 16'h0789, 1'b0, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
